// File: rtl/tff_chk_pkg.sv
// Shared types and defaults for the T flip-flop follow checker.
// Optional q high-time measurement is built when TFF_CHK_HIGH_TIME_EN is defined.
package tff_chk_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } chk_state_e;

endpackage

// File: rtl/tff_follow_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear and an increment in the same cycle load 1.
// Latency: value updates on the clock edge after inc/clr.
// Backpressure: none; the counter sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            // A restart can coincide with the first counted cycle.
            value <= inc ? ONE : '0;
        end else if (inc && (value != '1)) begin
            value <= value + ONE;
        end
    end

endmodule

// File: rtl/tff_follow_checker.sv
// Monitors a T flip-flop: checks q(k) == q(k-1) ^ t(k-1), counts toggles and violations, sticky err.
// Latency: a bad q at posedge k shows as mismatch after posedge k; TFF_CHK_HIGH_TIME_EN adds hi_len.
// Backpressure: none; pure observer, en=0 parks it in INIT and clr restarts it.
module tff_follow_checker
    import tff_chk_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             t,
    input  logic             q,
    output logic             armed,
    output logic             mismatch,
    output logic             err,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] hi_len,
    output logic             hi_len_vld
);

    chk_state_e state;
    chk_state_e state_nx;
    logic       t_d;
    logic       q_d;
    logic       active;
    logic       bad;
    logic       tog;

    // Comparisons need a held reference sample, so INIT never checks.
    assign active = en && !clr && (state != INIT);
    assign bad    = active && (q != (q_d ^ t_d));
    assign tog    = active && (q != q_d);
    assign armed  = (state == RUN) || (state == FAULT);

    always_comb begin
        state_nx = state;
        if (clr || !en) begin
            state_nx = INIT;
        end else begin
            case (state)
                INIT:    state_nx = RUN;
                RUN:     state_nx = bad ? FAULT : RUN;
                FAULT:   state_nx = FAULT;
                default: state_nx = INIT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            t_d      <= 1'b0;
            q_d      <= 1'b0;
            mismatch <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            mismatch <= bad;
            if (en) begin
                t_d <= t;
                q_d <= q;
            end
            if (clr) begin
                err <= 1'b0;
            end else if (bad) begin
                err <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_toggle_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (tog),
        .clr   (clr),
        .value (toggle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bad),
        .clr   (clr),
        .value (err_cnt)
    );

`ifdef TFF_CHK_HIGH_TIME_EN
    logic             q_rise;
    logic             q_fall;
    logic [CNT_W-1:0] hi_cnt;

    assign q_rise = active && q && !q_d;
    assign q_fall = active && !q && q_d;

    // A rise both clears and increments, so the running count restarts at 1.
    sat_counter #(.W(CNT_W)) u_hi_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (active && q),
        .clr   (clr || !en || q_rise),
        .value (hi_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_len     <= '0;
            hi_len_vld <= 1'b0;
        end else begin
            hi_len_vld <= q_fall;
            if (clr) begin
                hi_len <= '0;
            end else if (q_fall) begin
                hi_len <= hi_cnt;
            end
        end
    end
`else
    assign hi_len     = '0;
    assign hi_len_vld = 1'b0;
`endif

endmodule

// File: tb/tb_tff_follow_checker.sv
// Directed bench for tff_follow_checker, driven by a model T flip-flop that can be made to miss a toggle.
module tb_tff_follow_checker;
    import tff_chk_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         clr;
    logic         t;
    logic         q;
    logic         stuck;
    logic         model_q;
    logic         armed;
    logic         mismatch;
    logic         err;
    logic [W-1:0] toggle_cnt;
    logic [W-1:0] err_cnt;
    logic [W-1:0] hi_len;
    logic         hi_len_vld;

    int           checks = 0;
    int           errors = 0;
    int           mm_seen;
    int           vld_seen;
    logic [W-1:0] last_hi;

    always #5 clk = ~clk;

    // Model flop; stuck makes it ignore t for one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         model_q <= 1'b0;
        else if (!stuck) model_q <= model_q ^ t;
    end
    assign q = model_q;

    tff_follow_checker #(.CNT_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clr        (clr),
        .t          (t),
        .q          (q),
        .armed      (armed),
        .mismatch   (mismatch),
        .err        (err),
        .toggle_cnt (toggle_cnt),
        .err_cnt    (err_cnt),
        .hi_len     (hi_len),
        .hi_len_vld (hi_len_vld)
    );

    // Drive t for one posedge, then observe outputs at the following negedge.
    task automatic step(input logic t_v);
        t = t_v;
        @(negedge clk);
        if (mismatch === 1'b1) mm_seen++;
        if (hi_len_vld === 1'b1) begin
            vld_seen++;
            last_hi = hi_len;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0; t = 1'b0; stuck = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({armed, mismatch, err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {armed, mismatch, err}); end
        checks++; if (toggle_cnt !== 4'd0) begin errors++; $display("FAIL reset_toggle_cnt got %0d want 0", toggle_cnt); end
        checks++; if (err_cnt !== 4'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
        checks++; if ({hi_len, hi_len_vld} !== 5'd0) begin errors++; $display("FAIL reset_hi got %0d/%0b want 0/0", hi_len, hi_len_vld); end
        rst = 1'b0;
    endtask

    task automatic test_toggle();
        en = 1'b1; mm_seen = 0;
        step(1'b0);
        checks++; if (armed !== 1'b1) begin errors++; $display("FAIL toggle_armed got %b want 1", armed); end
        step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b0);
        checks++; if (toggle_cnt !== 4'd2) begin errors++; $display("FAIL toggle_cnt got %0d want 2", toggle_cnt); end
        checks++; if (err !== 1'b0 || err_cnt !== 4'd0) begin errors++; $display("FAIL toggle_err got %b/%0d want 0/0", err, err_cnt); end
        checks++; if (mm_seen !== 0) begin errors++; $display("FAIL toggle_mismatch got %0d want 0", mm_seen); end
    endtask

    task automatic test_mismatch();
        mm_seen = 0;
        stuck = 1'b1; step(1'b1); stuck = 1'b0;
        step(1'b0);
        checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL mm_pulse got %b want 1", mismatch); end
        step(1'b0);
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL mm_pulse_end got %b want 0", mismatch); end
        step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b0);
        checks++; if (mm_seen !== 1) begin errors++; $display("FAIL mm_count got %0d want 1", mm_seen); end
        checks++; if (err !== 1'b1 || err_cnt !== 4'd1) begin errors++; $display("FAIL mm_err got %b/%0d want 1/1", err, err_cnt); end
        checks++; if (dut.state !== FAULT || armed !== 1'b1) begin errors++; $display("FAIL mm_state got %0d/%b want 2/1", dut.state, armed); end
    endtask

    task automatic test_saturation();
        logic         wrapped;
        logic [W-1:0] prev;
        clr = 1'b1; step(1'b0); clr = 1'b0;
        checks++; if ({armed, err, toggle_cnt, err_cnt} !== 10'd0) begin errors++; $display("FAIL clr_state got %b/%b/%0d/%0d want 0/0/0/0", armed, err, toggle_cnt, err_cnt); end
        wrapped = 1'b0; prev = '0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1);
            if (toggle_cnt < prev) wrapped = 1'b1;
            prev = toggle_cnt;
        end
        checks++; if (toggle_cnt !== 4'd15) begin errors++; $display("FAIL sat_value got %0d want 15", toggle_cnt); end
        repeat (3) step(1'b1);
        checks++; if (toggle_cnt !== 4'd15 || wrapped !== 1'b0) begin errors++; $display("FAIL sat_hold got %0d wrap %b want 15 wrap 0", toggle_cnt, wrapped); end
    endtask

    task automatic test_clr_mismatch();
        clr = 1'b1; step(1'b0); clr = 1'b0;
        step(1'b0); step(1'b0);
        mm_seen = 0;
        stuck = 1'b1; step(1'b1); stuck = 1'b0;
        clr = 1'b1; step(1'b0); clr = 1'b0;
        checks++; if ({err, err_cnt, armed, mismatch} !== 7'd0) begin errors++; $display("FAIL clr_beats_mm got %b/%0d/%b/%b want 0/0/0/0", err, err_cnt, armed, mismatch); end
        step(1'b0); step(1'b0);
        checks++; if (mm_seen !== 0 || err !== 1'b0 || armed !== 1'b1) begin errors++; $display("FAIL clr_recover got mm %0d err %b armed %b want 0/0/1", mm_seen, err, armed); end
    endtask

    task automatic test_en_drop();
        clr = 1'b1; step(1'b0); clr = 1'b0;
        repeat (4) step(1'b1);
        checks++; if (toggle_cnt !== 4'd3) begin errors++; $display("FAIL en_pre_cnt got %0d want 3", toggle_cnt); end
        en = 1'b0; mm_seen = 0;
        repeat (3) step(1'b1);
        checks++; if (armed !== 1'b0 || toggle_cnt !== 4'd3) begin errors++; $display("FAIL en_off got armed %b cnt %0d want 0/3", armed, toggle_cnt); end
        en = 1'b1;
        step(1'b1);
        checks++; if (armed !== 1'b1 || toggle_cnt !== 4'd3) begin errors++; $display("FAIL en_rearm got armed %b cnt %0d want 1/3", armed, toggle_cnt); end
        step(1'b1);
        checks++; if (toggle_cnt !== 4'd4 || mm_seen !== 0) begin errors++; $display("FAIL en_resume got cnt %0d mm %0d want 4/0", toggle_cnt, mm_seen); end
    endtask

    task automatic test_high_time();
        rst = 1'b1; en = 1'b0; step(1'b0); step(1'b0);
        rst = 1'b0; en = 1'b1; vld_seen = 0; last_hi = '0;
        step(1'b0); step(1'b1); step(1'b0); step(1'b0); step(1'b1);
        step(1'b0);
`ifdef TFF_CHK_HIGH_TIME_EN
        checks++; if (hi_len_vld !== 1'b1 || hi_len !== 4'd3) begin errors++; $display("FAIL hi_pulse got vld %b len %0d want 1/3", hi_len_vld, hi_len); end
        step(1'b0);
        checks++; if (hi_len_vld !== 1'b0 || vld_seen !== 1 || hi_len !== 4'd3) begin errors++; $display("FAIL hi_once got vld %b seen %0d len %0d want 0/1/3", hi_len_vld, vld_seen, hi_len); end
`else
        step(1'b0);
        checks++; if (hi_len !== 4'd0 || vld_seen !== 0) begin errors++; $display("FAIL hi_tied got len %0d seen %0d want 0/0", hi_len, vld_seen); end
`endif
        vld_seen = 0;
        step(1'b1); step(1'b0); step(1'b0);
        #2 rst = 1'b1;
        #1;
        checks++; if ({armed, mismatch, err, toggle_cnt, err_cnt, hi_len, hi_len_vld} !== 16'd0) begin errors++; $display("FAIL async_rst got %b/%b/%b/%0d/%0d/%0d/%b want all 0", armed, mismatch, err, toggle_cnt, err_cnt, hi_len, hi_len_vld); end
        step(1'b0); step(1'b0);
        rst = 1'b0;
        repeat (3) step(1'b0);
        checks++; if (vld_seen !== 0 || hi_len !== 4'd0) begin errors++; $display("FAIL hi_rst_mid got seen %0d len %0d want 0/0", vld_seen, hi_len); end
    endtask

    initial begin
        test_reset();
        test_toggle();
        test_mismatch();
        test_saturation();
        test_clr_mismatch();
        test_en_drop();
        test_high_time();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
